// File: rtl/fft_pkg.sv
// Shared types and sizing helpers for the radix-2 DIT FFT stage sequencer.
// Included first so every design file can import it.
package fft_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        DRAIN = 3'd2,
        SWAP  = 3'd3,
        DONE  = 3'd4
    } fft_state_e;

    function automatic int addr_width(input int n);
        return $clog2(n);
    endfunction

    // Wide enough to hold 0..STAGES-1 and the STAGES-1 boundary compare.
    function automatic int stage_width(input int n);
        return $clog2($clog2(n)) + 1;
    endfunction

endpackage

// File: rtl/fft_addr_delay.sv
// Fixed-depth shift register that replays read strobes and address pairs as
// write strobes once the butterfly result is ready; sync clear empties it.
module fft_addr_delay
    import fft_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] r_pipe [DEPTH];

    // Shift every cycle; a clear flushes every slot so no stale write escapes.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign dout = r_pipe[DEPTH-1];

endmodule

// File: rtl/fft_stage_sequencer.sv
// Stage/butterfly sequencer for the in-place radix-2 DIT FFT on the ping-pong
// sample RAM: read pairs, delayed write pairs, twiddle index and bank control.
module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter int N             = 32,
    parameter int address_width = addr_width(N),
    parameter int BF_LATENCY    = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    output logic                          fft_busy,
    output logic                          done,
    output logic                          fft_read_en,
    output logic [address_width-1:0]      fft_rd_address1,
    output logic [address_width-1:0]      fft_rd_address2,
    output logic                          fft_wr_en,
    output logic [address_width-1:0]      fft_wr_address1,
    output logic [address_width-1:0]      fft_wr_address2,
    output logic                          bank_select,
    output logic [address_width-2:0]      tw_address,
    output logic [stage_width(N)-1:0]     stage
);

    localparam int STAGES  = $clog2(N);
    localparam int STAGE_W = stage_width(N);
    localparam int JW      = address_width - 1;
    localparam int DW      = $clog2(BF_LATENCY) + 1;
    localparam int DL_W    = 1 + 2 * address_width;

    fft_state_e             r_state;
    fft_state_e             w_state_nxt;
    logic [JW-1:0]          r_j;
    logic [JW-1:0]          w_j_nxt;
    logic [STAGE_W-1:0]     r_stage;
    logic [STAGE_W-1:0]     w_stage_nxt;
    logic [DW-1:0]          r_drain;
    logic [DW-1:0]          w_drain_nxt;

    logic [JW-1:0]            w_mask;
    logic [JW-1:0]            w_pos;
    logic [JW-1:0]            w_grp;
    logic [JW-1:0]            w_tw;
    logic [address_width-1:0] w_span;
    logic [address_width-1:0] w_a1;
    logic [address_width-1:0] w_a2;
    logic                     w_rd_en;
    logic                     w_busy;
    logic                     w_done;
    logic                     w_bank_nxt;

    logic                     r_rd_en;
    logic [address_width-1:0] r_rd_a1;
    logic [address_width-1:0] r_rd_a2;
    logic [JW-1:0]            r_tw;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_bank;

    logic [DL_W-1:0]          w_dl_in;
    logic [DL_W-1:0]          w_dl_out;

    // State register with butterfly, stage and drain counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_j     <= '0;
            r_stage <= '0;
            r_drain <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_j     <= w_j_nxt;
            r_stage <= w_stage_nxt;
            r_drain <= w_drain_nxt;
        end
    end

    // Next-state logic; j holds at N/2-1 through DRAIN and only wraps in SWAP.
    always_comb begin
        w_state_nxt = r_state;
        w_j_nxt     = r_j;
        w_stage_nxt = r_stage;
        w_drain_nxt = r_drain;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = READ;
                    w_j_nxt     = '0;
                    w_stage_nxt = '0;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            READ: begin
                if (r_j == JW'(N / 2 - 1)) begin
                    w_state_nxt = DRAIN;
                    w_drain_nxt = '0;
                end else begin
                    w_j_nxt = r_j + JW'(1);
                end
            end
            DRAIN: begin
                if (r_drain == DW'(BF_LATENCY - 1)) begin
                    w_state_nxt = SWAP;
                end else begin
                    w_drain_nxt = r_drain + DW'(1);
                end
            end
            SWAP: begin
                w_j_nxt = '0;
                if (r_stage == STAGE_W'(STAGES - 1)) begin
                    w_state_nxt = DONE;
                end else begin
                    w_stage_nxt = r_stage + STAGE_W'(1);
                    w_state_nxt = READ;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output decode from the next state so registered outputs line up with it.
    always_comb begin
        w_mask     = ~({JW{1'b1}} << w_stage_nxt);
        w_pos      = w_j_nxt & w_mask;
        w_grp      = w_j_nxt >> w_stage_nxt;
        w_span     = {{(address_width-1){1'b0}}, 1'b1} << w_stage_nxt;
        w_rd_en    = (w_state_nxt == READ);
        w_busy     = (w_state_nxt != IDLE);
        w_done     = (w_state_nxt == DONE);
        w_bank_nxt = r_bank ^ (w_state_nxt == SWAP);
        if (w_rd_en) begin
            w_a1 = ({1'b0, w_grp} << (w_stage_nxt + STAGE_W'(1))) | {1'b0, w_pos};
            w_a2 = w_a1 + w_span;
            w_tw = w_pos << (STAGE_W'(STAGES - 1) - w_stage_nxt);
        end else begin
            w_a1 = '0;
            w_a2 = '0;
            w_tw = '0;
        end
    end

    // Registered read-side outputs and control flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_en <= 1'b0;
            r_rd_a1 <= '0;
            r_rd_a2 <= '0;
            r_tw    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_bank  <= 1'b0;
        end else begin
            r_rd_en <= w_rd_en;
            r_rd_a1 <= w_a1;
            r_rd_a2 <= w_a2;
            r_tw    <= w_tw;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_bank  <= w_bank_nxt;
        end
    end

    assign w_dl_in = {r_rd_en, r_rd_a1, r_rd_a2};

    fft_addr_delay #(
        .DEPTH (BF_LATENCY),
        .WIDTH (DL_W)
    ) u_wr_delay (
        .clk  (clk),
        .clr  (reset),
        .din  (w_dl_in),
        .dout (w_dl_out)
    );

    assign fft_read_en     = r_rd_en;
    assign fft_rd_address1 = r_rd_a1;
    assign fft_rd_address2 = r_rd_a2;
    assign tw_address      = r_tw;
    assign fft_busy        = r_busy;
    assign done            = r_done;
    assign bank_select     = r_bank;
    assign stage           = r_stage;
    assign fft_wr_en       = w_dl_out[DL_W-1];
    assign fft_wr_address1 = w_dl_out[2*address_width-1:address_width];
    assign fft_wr_address2 = w_dl_out[address_width-1:0];

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench: N=8/BF=3 instance for address tables, timing, start filtering
// and mid-run reset; N=32/BF=1 instance for per-stage write coverage.
module tb_fft_stage_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic       a_reset, a_start, a_busy, a_done, a_rd_en, a_wr_en, a_bank;
    logic [2:0] a_rd1, a_rd2, a_wr1, a_wr2, a_stage;
    logic [1:0] a_tw;

    logic       b_reset, b_start, b_busy, b_done, b_rd_en, b_wr_en, b_bank;
    logic [4:0] b_rd1, b_rd2, b_wr1, b_wr2;
    logic [3:0] b_tw, b_stage;

    fft_stage_sequencer #(.N(8), .BF_LATENCY(3)) u_dut_a (
        .clk(clk), .reset(a_reset), .start(a_start), .fft_busy(a_busy), .done(a_done),
        .fft_read_en(a_rd_en), .fft_rd_address1(a_rd1), .fft_rd_address2(a_rd2),
        .fft_wr_en(a_wr_en), .fft_wr_address1(a_wr1), .fft_wr_address2(a_wr2),
        .bank_select(a_bank), .tw_address(a_tw), .stage(a_stage)
    );

    fft_stage_sequencer #(.N(32), .BF_LATENCY(1)) u_dut_b (
        .clk(clk), .reset(b_reset), .start(b_start), .fft_busy(b_busy), .done(b_done),
        .fft_read_en(b_rd_en), .fft_rd_address1(b_rd1), .fft_rd_address2(b_rd2),
        .fft_wr_en(b_wr_en), .fft_wr_address1(b_wr1), .fft_wr_address2(b_wr2),
        .bank_select(b_bank), .tw_address(b_tw), .stage(b_stage)
    );

    // Hand-computed butterfly order for N=8: stage0, stage1, stage2.
    int e_a1 [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
    int e_a2 [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
    int e_tw [12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

    int cnt [5][32];

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Table index for run-relative cycle cc of the N=8 run, or -1 if no read.
    function automatic int read_index(input int cc);
        if (cc >= 1 && cc <= 24 && ((cc - 1) % 8) < 4) begin
            return ((cc - 1) / 8) * 4 + ((cc - 1) % 8);
        end
        return -1;
    endfunction

    function automatic int bank_base(input int cc);
        if (cc >= 24) return 1;
        if (cc >= 16) return 0;
        if (cc >= 8)  return 1;
        return 0;
    endfunction

    initial begin
        int run, cc, ri, wi, s, bad, nwr, done_cyc;
        bit wr_seen;
        a_reset = 1'b1; a_start = 1'b0;
        b_reset = 1'b1; b_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        a_reset = 1'b0; b_reset = 1'b0;
        @(negedge clk);
        check_eq("rst_a_rd_en", int'(a_rd_en), 0);
        check_eq("rst_a_wr_en", int'(a_wr_en), 0);
        check_eq("rst_a_busy",  int'(a_busy),  0);
        check_eq("rst_a_done",  int'(a_done),  0);
        check_eq("rst_a_bank",  int'(a_bank),  0);
        check_eq("rst_a_stage", int'(a_stage), 0);
        check_eq("rst_b_bank",  int'(b_bank),  0);
        check_eq("rst_b_busy",  int'(b_busy),  0);
        @(posedge clk);
        #1;

        // Two back-to-back runs; starts at 5 and 25 must be ignored.
        for (int c = 0; c <= 53; c++) begin
            a_start = (c == 0 || c == 5 || c == 25 || c == 26);
            @(negedge clk);
            run = (c >= 26) ? 1 : 0;
            cc  = c - 26 * run;
            ri  = read_index(cc);
            wi  = read_index(cc - 3);
            check_eq($sformatf("rd_en@%0d", c), int'(a_rd_en), (ri >= 0) ? 1 : 0);
            check_eq($sformatf("rd1@%0d", c),   int'(a_rd1),   (ri >= 0) ? e_a1[ri] : 0);
            check_eq($sformatf("rd2@%0d", c),   int'(a_rd2),   (ri >= 0) ? e_a2[ri] : 0);
            check_eq($sformatf("tw@%0d", c),    int'(a_tw),    (ri >= 0) ? e_tw[ri] : 0);
            check_eq($sformatf("wr_en@%0d", c), int'(a_wr_en), (wi >= 0) ? 1 : 0);
            if (wi >= 0) begin
                check_eq($sformatf("wr1@%0d", c), int'(a_wr1), e_a1[wi]);
                check_eq($sformatf("wr2@%0d", c), int'(a_wr2), e_a2[wi]);
            end
            check_eq($sformatf("busy@%0d", c), int'(a_busy), (cc >= 1 && cc <= 25) ? 1 : 0);
            check_eq($sformatf("done@%0d", c), int'(a_done), (cc == 25) ? 1 : 0);
            check_eq($sformatf("bank@%0d", c), int'(a_bank), bank_base(cc) ^ run);
            if (cc >= 1 && cc <= 24) begin
                check_eq($sformatf("stage@%0d", c), int'(a_stage), (cc - 1) / 8);
            end
            @(posedge clk);
            #1;
        end
        a_start = 1'b0;

        // Reset in cycle 10 of a run: everything quiet afterwards.
        wr_seen = 1'b0;
        for (int c = 0; c <= 40; c++) begin
            a_start = (c == 0);
            a_reset = (c == 10);
            @(negedge clk);
            if (c == 9) begin
                check_eq("mid_busy@9", int'(a_busy), 1);
                check_eq("mid_bank@9", int'(a_bank), 1);
            end
            if (c >= 11) begin
                if (a_wr_en) wr_seen = 1'b1;
                check_eq($sformatf("rr_rd_en@%0d", c), int'(a_rd_en), 0);
                check_eq($sformatf("rr_rd1@%0d", c),   int'(a_rd1),   0);
                check_eq($sformatf("rr_wr1@%0d", c),   int'(a_wr1),   0);
                check_eq($sformatf("rr_busy@%0d", c),  int'(a_busy),  0);
                check_eq($sformatf("rr_done@%0d", c),  int'(a_done),  0);
                check_eq($sformatf("rr_bank@%0d", c),  int'(a_bank),  0);
                check_eq($sformatf("rr_stage@%0d", c), int'(a_stage), 0);
            end
            @(posedge clk);
            #1;
        end
        a_reset = 1'b0;
        check_eq("rr_no_write", int'(wr_seen), 0);

        // N=32, BF=1: per-stage write coverage scoreboard.
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 32; k++) cnt[i][k] = 0;
        end
        nwr = 0;
        done_cyc = -1;
        bad = 0;
        for (int c = 0; c <= 95; c++) begin
            b_start = (c == 0);
            @(negedge clk);
            if (b_wr_en) begin
                nwr++;
                s = (c - 2) / 18;
                if (c >= 2 && s < 5) begin
                    cnt[s][int'(b_wr1)]++;
                    cnt[s][int'(b_wr2)]++;
                end else begin
                    bad++;
                end
            end
            if (b_done && done_cyc < 0) done_cyc = c;
            check_eq($sformatf("b_rd_en@%0d", c), int'(b_rd_en),
                     (c >= 1 && c <= 90 && ((c - 1) % 18) < 16) ? 1 : 0);
            @(posedge clk);
            #1;
        end
        b_start = 1'b0;
        check_eq("b_done_cycle", done_cyc, 91);
        check_eq("b_write_count", nwr, 80);
        check_eq("b_stray_write", bad, 0);
        check_eq("b_bank_final", int'(b_bank), 1);
        for (int i = 0; i < 5; i++) begin
            bad = 0;
            for (int k = 0; k < 32; k++) begin
                if (cnt[i][k] != 1) bad++;
            end
            check_eq($sformatf("b_cover_stage%0d", i), bad, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
